// File: rtl/s_inter_rx.sv
// rtl/s_inter_rx.sv - slave-side transaction-layer receiver rebuilding AXI R/B channels from link packets
module s_inter_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH*8-1:0] rx_data,
    input  logic [DATA_WIDTH-1:0]   rx_keep,
    input  logic                    rx_last,
    input  logic [3:0]              rx_connection_id,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [DATA_WIDTH*8-1:0] s_axi_rdata,
    output logic [21:0]             s_axi_rid,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [21:0]             s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [15:0]             err_cnt
);

    localparam logic [3:0]            TYPE_B = 4'b0100;
    localparam logic [3:0]            TYPE_R = 4'b0101;
    localparam logic [DATA_WIDTH-1:0] B_KEEP = DATA_WIDTH'(16'h0007);

    typedef enum logic [1:0] {HDR, R_DATA, DROP} state_t;

    state_t                  r_state;
    logic [7:0]              r_cnt;
    logic [17:0]             r_hdr_id;
    logic [1:0]              r_hdr_resp;
    logic [3:0]              r_hdr_conn;
    logic [DATA_WIDTH*8-1:0] r_rdata;
    logic [21:0]             r_rid;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic                    r_rvalid;
    logic [21:0]             r_bid;
    logic [1:0]              r_bresp;
    logic                    r_bvalid;
    logic [15:0]             r_err_cnt;

    logic w_is_b;
    logic w_is_r;
    logic w_cnt_zero;
    logic w_rx_ready;
    logic w_acc;
    logic w_err;

    assign w_is_b     = (rx_data[3:0] == TYPE_B);
    assign w_is_r     = (rx_data[3:0] == TYPE_R);
    assign w_cnt_zero = (r_cnt == 8'd0);

    // B headers need the B slot; R/illegal headers are always taken so DROP can discard them
    always_comb begin
        w_rx_ready = 1'b0;
        if (!reset) begin
            case (r_state)
                HDR:     w_rx_ready = w_is_b ? (~r_bvalid | s_axi_bready) : 1'b1;
                R_DATA:  w_rx_ready = ~r_rvalid | s_axi_rready;
                default: w_rx_ready = 1'b1;
            endcase
        end
    end

    assign w_acc = rx_valid & w_rx_ready;

    always_comb begin
        w_err = 1'b0;
        if (w_acc) begin
            case (r_state)
                HDR:     w_err = w_is_b ? (~rx_last | (rx_keep != B_KEEP))
                                        : (w_is_r ? rx_last : 1'b1);
                R_DATA:  w_err = w_cnt_zero ? ~rx_last : rx_last;
                default: w_err = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= HDR;
            r_cnt      <= 8'd0;
            r_hdr_id   <= '0;
            r_hdr_resp <= '0;
            r_hdr_conn <= '0;
            r_rdata    <= '0;
            r_rid      <= '0;
            r_rresp    <= '0;
            r_rlast    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= '0;
            r_bvalid   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (r_rvalid && s_axi_rready) r_rvalid <= 1'b0;
            if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
            if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;

            // a load below overrides the drain above, giving one beat per cycle
            if (w_acc) begin
                case (r_state)
                    HDR: begin
                        if (w_is_b) begin
                            r_bvalid <= 1'b1;
                            r_bid    <= {rx_connection_id, rx_data[23:6]};
                            r_bresp  <= rx_data[5:4];
                            r_state  <= rx_last ? HDR : DROP;
                        end else if (w_is_r) begin
                            r_hdr_id   <= rx_data[23:6];
                            r_hdr_resp <= rx_data[5:4];
                            r_hdr_conn <= rx_connection_id;
                            r_cnt      <= rx_data[31:24];
                            r_state    <= rx_last ? HDR : R_DATA;
                        end else begin
                            r_state <= rx_last ? HDR : DROP;
                        end
                    end
                    R_DATA: begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= rx_data;
                        r_rid    <= {r_hdr_conn, r_hdr_id};
                        r_rresp  <= r_hdr_resp;
                        r_rlast  <= w_cnt_zero | rx_last;
                        r_cnt    <= r_cnt - 8'd1;
                        if (rx_last)         r_state <= HDR;
                        else if (w_cnt_zero) r_state <= DROP;
                    end
                    default: begin
                        if (rx_last) r_state <= HDR;
                    end
                endcase
            end
        end
    end

    assign rx_ready     = w_rx_ready;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rid    = r_rid;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rlast  = r_rlast;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_bid    = r_bid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_bvalid = r_bvalid;
    assign err_cnt      = r_err_cnt;

endmodule
